// File: rtl/meas_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// meas_sequencer_pkg
//
// Shared definitions for the measurement sequencer:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - bit positions inside the 3-bit status word {timeout_err, done, busy}
//   - small decode helpers used to build the registered outputs
// -----------------------------------------------------------------------------
package meas_sequencer_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_HOLDOFF    = 3'd1;
  localparam logic [STATE_W-1:0] ST_TRIG       = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_VALID = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE       = 3'd4;
  localparam logic [STATE_W-1:0] ST_ERROR      = 3'd5;

  // Status word bit positions.
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;
  localparam int STAT_W           = 3;

  // A sequence is "in flight" while it is counting, triggering or waiting.
  function automatic logic state_is_busy(input logic [STATE_W-1:0] st);
    return (st == ST_HOLDOFF) || (st == ST_TRIG) || (st == ST_WAIT_VALID);
  endfunction

  // Status word for a given state.
  function automatic logic [STAT_W-1:0] status_of(input logic [STATE_W-1:0] st);
    logic [STAT_W-1:0] s;
    s                   = '0;
    s[STAT_BUSY_BIT]    = state_is_busy(st);
    s[STAT_DONE_BIT]    = (st == ST_DONE);
    s[STAT_TIMEOUT_BIT] = (st == ST_ERROR);
    return s;
  endfunction

endpackage : meas_sequencer_pkg

// File: rtl/meas_sequencer_clk_counter.sv
// -----------------------------------------------------------------------------
// clk_counter
//
// Free-running clock counter with synchronous clear, count enable and a
// terminal-count compare. Used twice by meas_sequencer: once for the holdoff
// interval and once for the valid timeout.
//
// Ports:
//   clk      in   system clock (rising edge)
//   reset    in   synchronous active-high reset, clears the count
//   clear_i  in   synchronous clear (has priority over en_i)
//   en_i     in   count enable, +1 per clock
//   limit_i  in   terminal value
//   hit_o    out  high when the count after this clock's increment would be
//                 >= limit_i; a limit of 0 therefore hits on the first clock
// -----------------------------------------------------------------------------
module clk_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         hit_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   count_inc;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    count_d   = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_inc[W-1:0];
    end
  end

  // Compare one bit wider than the counter so a limit of all-ones still
  // terminates instead of wrapping past it.
  assign hit_o = (count_inc >= {1'b0, limit_i});

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : clk_counter

// File: rtl/meas_sequencer.sv
// -----------------------------------------------------------------------------
// meas_sequencer
//
// Drives an ADC through a sequence of conversions: wait a holdoff interval,
// pulse a conversion request, wait (optionally with timeout) for the result,
// and repeat until the programmed number of samples is collected (or forever
// when the sample count is 0). Completion and timeout raise an interrupt and
// are held until the MCU drops arm_i.
//
// Ports:
//   clk                    in   system clock (rising edge)
//   reset                  in   synchronous active-high reset
//   arm_i                  in   level: 1 = run sequence, 0 = abort / idle
//   p_sample_count_i       in   samples per sequence, 0 = continuous
//   p_clk_count_holdoff_i  in   clocks from a completed sample to next trigger
//   p_clk_count_timeout_i  in   max clocks from trigger to error, 0 = none
//   adc_measure_valid_i    in   ADC result ready (pulse or level)
//   adc_measure_trig_o     out  one-clock conversion request
//   meas_complete_o        out  sequence finished
//   spi_interrupt_o        out  MCU interrupt (done or timeout)
//   sample_idx_o           out  samples completed in this sequence
//   status_o               out  {timeout_err, done, busy}
//   monitor_o              out  {adc_measure_trig_o, adc_measure_valid_i}
//
// Timing:
//   - HOLDOFF lasts max(holdoff, 1) clocks.
//   - The timeout counter runs from the trigger clock; with timeout = T the
//     ERROR state is entered T clocks after the trigger (at least 2), and a
//     valid arriving on that same clock is still counted.
//   - All outputs except monitor_o come straight from flops, computed from
//     the next state so they line up with the state register.
// -----------------------------------------------------------------------------
module meas_sequencer
  import meas_sequencer_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int SMP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_i,
  input  logic [SMP_W-1:0]  p_sample_count_i,
  input  logic [CNT_W-1:0]  p_clk_count_holdoff_i,
  input  logic [CNT_W-1:0]  p_clk_count_timeout_i,
  input  logic              adc_measure_valid_i,
  output logic              adc_measure_trig_o,
  output logic              meas_complete_o,
  output logic              spi_interrupt_o,
  output logic [SMP_W-1:0]  sample_idx_o,
  output logic [STAT_W-1:0] status_o,
  output logic [1:0]        monitor_o
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [SMP_W-1:0]   sample_idx_q;
  logic [SMP_W-1:0]   sample_idx_d;
  logic [SMP_W-1:0]   sample_idx_inc;
  logic               trig_q;
  logic               trig_d;
  logic               complete_q;
  logic               complete_d;
  logic               irq_q;
  logic               irq_d;
  logic [STAT_W-1:0]  status_q;
  logic [STAT_W-1:0]  status_d;

  logic holdoff_clear;
  logic holdoff_en;
  logic holdoff_hit;
  logic timeout_clear;
  logic timeout_en;
  logic timeout_hit;
  logic timeout_enabled;
  logic seq_limited;

  // ---------------------------------------------------------------------------
  // Interval counters. Both are held at zero outside their window, so the
  // first clock of the window always starts from a clean count.
  // ---------------------------------------------------------------------------
  assign holdoff_en    = (state_q == ST_HOLDOFF);
  assign holdoff_clear = !holdoff_en;

  // The timeout window starts on the trigger clock itself.
  assign timeout_en    = (state_q == ST_TRIG) || (state_q == ST_WAIT_VALID);
  assign timeout_clear = !timeout_en;

  clk_counter #(
    .W (CNT_W)
  ) u_holdoff_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (holdoff_clear),
    .en_i    (holdoff_en),
    .limit_i (p_clk_count_holdoff_i),
    .hit_o   (holdoff_hit)
  );

  clk_counter #(
    .W (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (timeout_clear),
    .en_i    (timeout_en),
    .limit_i (p_clk_count_timeout_i),
    .hit_o   (timeout_hit)
  );

  assign timeout_enabled = (p_clk_count_timeout_i != '0);
  assign seq_limited     = (p_sample_count_i != '0);
  assign sample_idx_inc  = sample_idx_q + {{(SMP_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Next-state logic. Dropping arm_i takes priority in every state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sample_idx_d = sample_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d      = ST_HOLDOFF;
          sample_idx_d = '0;
        end
      end

      ST_HOLDOFF: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else if (holdoff_hit) begin
          state_d = ST_TRIG;
        end
      end

      ST_TRIG: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_VALID;
        end
      end

      ST_WAIT_VALID: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else if (adc_measure_valid_i) begin
          // Valid is checked before the timeout so a coincident result wins.
          // A held-high valid is counted once per entry because the state
          // leaves WAIT_VALID on the same clock.
          sample_idx_d = sample_idx_inc;
          if (seq_limited && (sample_idx_inc == p_sample_count_i)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end else if (timeout_enabled && timeout_hit) begin
          state_d = ST_ERROR;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they change on the
  // same edge as state_q without a combinational path to the pins.
  always_comb begin
    trig_d     = (state_d == ST_TRIG);
    complete_d = (state_d == ST_DONE);
    irq_d      = (state_d == ST_DONE) || (state_d == ST_ERROR);
    status_d   = status_of(state_d);
  end

  // NOTE: reset is synchronous and covers every flop, so a reset mid-sequence
  // returns all outputs to zero on the very next clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sample_idx_q <= '0;
      trig_q       <= 1'b0;
      complete_q   <= 1'b0;
      irq_q        <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      sample_idx_q <= sample_idx_d;
      trig_q       <= trig_d;
      complete_q   <= complete_d;
      irq_q        <= irq_d;
      status_q     <= status_d;
    end
  end

  assign adc_measure_trig_o = trig_q;
  assign meas_complete_o    = complete_q;
  assign spi_interrupt_o    = irq_q;
  assign sample_idx_o       = sample_idx_q;
  assign status_o           = status_q;

  // Scope probe: the valid input is deliberately passed through unregistered.
  assign monitor_o = {trig_q, adc_measure_valid_i};

endmodule : meas_sequencer

// File: tb/tb_meas_sequencer.sv
// -----------------------------------------------------------------------------
// tb_meas_sequencer
//
// Self-checking bench for meas_sequencer. For each scenario the expected
// per-clock behaviour is worked out up front from the sequencing rules
// (trigger times, valid-sampling edges, done/error edges) with plain
// arithmetic, then the scenario is played and every clock is compared.
//
// Timing model (edge 1 = first clock edge at which arm_i=1 is sampled):
//   L = max(holdoff,1), W = max(timeout-1,1) (unbounded when timeout = 0)
//   first trigger visible after edge 1+L
//   valid delay d (1..W) after a trigger at edge t is sampled at edge t+d+1
//   next trigger at (t+d+1)+L; error visible after edge t+W+1
// -----------------------------------------------------------------------------
module tb_meas_sequencer;

  localparam int CNT_W = 24;
  localparam int SMP_W = 8;
  localparam int MAXE  = 1100;
  localparam int NEVER = 1 << 30;

  logic             clk = 1'b0;
  logic             reset;
  logic             arm_i;
  logic [SMP_W-1:0] p_sample_count_i;
  logic [CNT_W-1:0] p_clk_count_holdoff_i;
  logic [CNT_W-1:0] p_clk_count_timeout_i;
  logic             adc_measure_valid_i;
  logic             adc_measure_trig_o;
  logic             meas_complete_o;
  logic             spi_interrupt_o;
  logic [SMP_W-1:0] sample_idx_o;
  logic [2:0]       status_o;
  logic [1:0]       monitor_o;

  always #5 clk = ~clk;

  meas_sequencer #(
    .CNT_W (CNT_W),
    .SMP_W (SMP_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .arm_i                 (arm_i),
    .p_sample_count_i      (p_sample_count_i),
    .p_clk_count_holdoff_i (p_clk_count_holdoff_i),
    .p_clk_count_timeout_i (p_clk_count_timeout_i),
    .adc_measure_valid_i   (adc_measure_valid_i),
    .adc_measure_trig_o    (adc_measure_trig_o),
    .meas_complete_o       (meas_complete_o),
    .spi_interrupt_o       (spi_interrupt_o),
    .sample_idx_o          (sample_idx_o),
    .status_o              (status_o),
    .monitor_o             (monitor_o)
  );

  int checks = 0;
  int errors = 0;

  int dly_q[$];
  bit exp_trig[MAXE];
  bit vld_at[MAXE];

  // {trig, complete, irq, status[2:0], monitor[1:0], sample_idx[7:0]}
  function automatic logic [31:0] observed();
    return {16'h0, adc_measure_trig_o, meas_complete_o, spi_interrupt_o,
            status_o, monitor_o, sample_idx_o};
  endfunction

  function automatic logic [31:0] expected(input bit tr, input bit dn, input bit er,
                                           input bit busy, input bit vld,
                                           input logic [SMP_W-1:0] idx);
    return {16'h0, tr, dn, dn | er, er, dn, busy, tr, vld, idx};
  endfunction

  task automatic check(input string tag, input int e, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, e, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Plays one armed window of `a` edges followed by 3 disarmed edges.
  // Valid delays come from dly_q (0 = withheld); `level` holds valid high.
  task automatic run_case(input string tag, input int n, input int h, input int t,
                          input int a, input bit level);
    int L, W, trig, cnt, i, d, v, done_e, err_e;
    logic [SMP_W-1:0] idx;
    bit tr, dn, er, busy, vld;

    L      = (h == 0) ? 1 : h;
    W      = (t == 0) ? NEVER : ((t <= 1) ? 1 : t - 1);
    done_e = NEVER;
    err_e  = NEVER;
    cnt    = 0;
    i      = 0;
    for (int e = 0; e < MAXE; e++) begin
      exp_trig[e] = 1'b0;
      vld_at[e]   = 1'b0;
    end

    trig = 1 + L;
    while (trig <= a) begin
      exp_trig[trig] = 1'b1;
      d = level ? 1 : ((i < dly_q.size()) ? dly_q[i] : 0);
      if (d == 0 || d > W) begin
        if (t != 0) err_e = trig + W + 1;
        break;
      end
      v = trig + d + 1;
      if (v > a) break;
      vld_at[v] = 1'b1;
      cnt++;
      if (n != 0 && cnt == n) begin
        done_e = v;
        break;
      end
      trig = v + L;
      i++;
    end

    p_sample_count_i      = SMP_W'(n);
    p_clk_count_holdoff_i = CNT_W'(h);
    p_clk_count_timeout_i = CNT_W'(t);
    idx = '0;

    for (int e = 1; e <= a + 3; e++) begin
      arm_i = (e <= a);
      vld   = (e <= a) && (level || vld_at[e]);
      adc_measure_valid_i = vld;
      step();
      if (vld_at[e]) idx++;
      tr   = (e <= a) && exp_trig[e];
      dn   = (e <= a) && (e >= done_e);
      er   = (e <= a) && (e >= err_e);
      busy = (e <= a) && (e < done_e) && (e < err_e);
      check(tag, e, observed(), expected(tr, dn, er, busy, vld, idx));
    end
    adc_measure_valid_i = 1'b0;
  endtask

  initial begin
    int n, h, t, a, d;

    // Reset overrides an asserted arm_i.
    reset = 1'b1;
    arm_i = 1'b1;
    adc_measure_valid_i   = 1'b0;
    p_sample_count_i      = '0;
    p_clk_count_holdoff_i = '0;
    p_clk_count_timeout_i = '0;
    step();
    check("reset_state", 1, observed(), 32'h0);
    step();
    check("reset_state", 2, observed(), 32'h0);
    arm_i = 1'b0;
    reset = 1'b0;
    step();
    check("idle_after_reset", 3, observed(), 32'h0);

    // Three samples, holdoff 10, valid 5 clocks after each trigger.
    dly_q = '{5, 5, 5};
    run_case("count3_hold10", 3, 10, 0, 80, 1'b0);

    // Timeout 20 with the second valid withheld.
    dly_q = '{3, 0};
    run_case("timeout20", 3, 4, 20, 60, 1'b0);

    // Valid on the timeout terminal clock is counted; one later is an error.
    dly_q = '{19, 19};
    run_case("valid_at_timeout", 2, 2, 20, 80, 1'b0);
    dly_q = '{20};
    run_case("valid_after_timeout", 1, 2, 20, 50, 1'b0);

    // Smallest timeout.
    dly_q = '{1, 1};
    run_case("timeout1_ok", 2, 0, 1, 30, 1'b0);
    dly_q = '{2};
    run_case("timeout1_err", 2, 0, 1, 30, 1'b0);

    // Valid held high: one count per WAIT_VALID entry.
    dly_q.delete();
    run_case("valid_level", 4, 2, 0, 40, 1'b1);

    // Continuous mode, holdoff 0: index wraps, never completes.
    run_case("continuous_wrap", 0, 0, 0, 800, 1'b1);

    // Abort in HOLDOFF after one sample.
    dly_q = '{2, 2, 2, 2};
    run_case("abort_holdoff", 4, 6, 0, 12, 1'b0);

    // Reset while waiting for valid, then re-arm with arm_i still high.
    p_sample_count_i      = SMP_W'(2);
    p_clk_count_holdoff_i = CNT_W'(3);
    p_clk_count_timeout_i = '0;
    arm_i = 1'b1;
    repeat (6) step();
    check("wait_valid_busy", 6, observed(), expected(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    reset = 1'b1;
    step();
    check("reset_in_wait", 7, observed(), 32'h0);
    reset = 1'b0;
    step();
    check("rearm_after_reset", 8, observed(), expected(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    arm_i = 1'b0;
    step();
    check("disarm_after_rearm", 9, observed(), 32'h0);

    // Randomised sequences, some aborted early.
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(1, 5));
      h = int'($urandom_range(0, 6));
      t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
      dly_q.delete();
      for (int k = 0; k < 6; k++) begin
        d = int'($urandom_range(1, 14));
        if ($urandom_range(0, 9) == 0) d = 0;
        dly_q.push_back(d);
      end
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 60)) : 200;
      run_case("random", n, h, t, a, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_meas_sequencer

// File: doc/meas_sequencer.md
MEAS_SEQUENCER -- requirements
Module: meas_sequencer

Interface
REQ-001 Parameter CNT_W, default 24: width of the holdoff and timeout clock counters.
REQ-002 Parameter SMP_W, default 16: width of the sample counter.
REQ-003 clk  input  1: single system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 arm_i  input  1: level; high = run the sequence, low = abort/idle.
REQ-006 p_sample_count_i  input  SMP_W: samples per sequence; 0 = continuous.
REQ-007 p_clk_count_holdoff_i  input  CNT_W: clocks between completed sample and next trigger.
REQ-008 p_clk_count_timeout_i  input  CNT_W: max clocks waiting for valid; 0 = no timeout.
REQ-009 adc_measure_valid_i  input  1: ADC result-ready pulse/level.
REQ-010 adc_measure_trig_o  output  1: ADC conversion request.
REQ-011 meas_complete_o  output  1: sequence finished.
REQ-012 spi_interrupt_o  output  1: MCU interrupt, active high.
REQ-013 sample_idx_o  output  SMP_W: count of samples completed in the current sequence.
REQ-014 status_o  output  3: {timeout_err, done, busy}.
REQ-015 monitor_o  output  2: {adc_measure_trig_o, adc_measure_valid_i} for scope.

Function
REQ-016 FSM states SHALL be IDLE, HOLDOFF, TRIG, WAIT_VALID, DONE, ERROR.
REQ-017 IDLE: the block SHALL go to HOLDOFF when arm_i=1 sampled, clearing sample_idx_o and the holdoff counter.
REQ-018 HOLDOFF: the counter SHALL increment each clock; the block SHALL go to TRIG when count == p_clk_count_holdoff_i (0 gives one HOLDOFF cycle).
REQ-019 TRIG: adc_measure_trig_o SHALL be high for exactly one clock, then the block SHALL go to WAIT_VALID with the timeout counter cleared.
REQ-020 WAIT_VALID: on adc_measure_valid_i=1, sample_idx_o SHALL increment (wrapping modulo 2^SMP_W).
REQ-021 On valid in WAIT_VALID, the block SHALL go to DONE if p_sample_count_i!=0 and the new sample_idx_o == p_sample_count_i, otherwise to HOLDOFF.
REQ-022 A valid level held high SHALL count once per WAIT_VALID entry; the edge is not required.
REQ-023 WAIT_VALID: if p_clk_count_timeout_i!=0 and the timeout counter reaches it with no valid, the block SHALL go to ERROR.
REQ-024 If valid and timeout occur in the same clock, valid SHALL win.
REQ-025 DONE: meas_complete_o=1, spi_interrupt_o=1, status done=1; state held until arm_i=0, then IDLE.
REQ-026 ERROR: spi_interrupt_o=1, timeout_err=1, no trig; state held until arm_i=0, then IDLE.
REQ-027 arm_i=0 in HOLDOFF/TRIG/WAIT_VALID SHALL abort to IDLE on the next clock, with no further trig and no interrupt; a trig already issued is not retracted.
REQ-028 busy SHALL be 1 in HOLDOFF, TRIG and WAIT_VALID, and 0 otherwise.
REQ-029 Parameter inputs SHALL be sampled live; the MCU changes them only while IDLE.
REQ-030 All outputs SHALL be registered: no combinational path from input to output except monitor_o[0]/[1].

Reset
REQ-031 reset=1 SHALL override all inputs: state=IDLE, all counters 0, and adc_measure_trig_o, meas_complete_o, spi_interrupt_o, sample_idx_o and status_o all 0.
REQ-032 reset mid-sequence SHALL give reset values on the next clock; re-arm requires arm_i to be high after reset is released.

Structure
REQ-033 State encodings and status bit indices SHALL live in a shared defines include used by top and register_set.
REQ-034 One sub-module is natural: clk_counter (clear, enable, terminal compare), instantiated for holdoff and timeout.
REQ-035 top SHALL drive arm_i from reg_sa_arm_trigger[0] and route status_o and sample_idx_o into reg_status.

Verification
REQ-036 count=3, holdoff=10, valid 5 clocks after each trig -> 3 one-cycle trigs 16 clocks apart, then meas_complete_o=1, sample_idx_o=3.
REQ-037 count=0, holdoff=0 -> trigs continue indefinitely, sample_idx_o wraps 0xFFFF->0, meas_complete_o never set.
REQ-038 timeout=20, valid withheld -> ERROR at 20 clocks after trig, timeout_err=1, spi_interrupt_o=1; arm_i=0 -> IDLE, all flags clear.
REQ-039 valid coincident with timeout terminal count -> sample counted, no ERROR.
REQ-040 arm_i dropped in HOLDOFF after 1 sample -> IDLE next clock, no trig, no interrupt; reset asserted in WAIT_VALID -> all outputs 0 next clock.
